// File: rtl/pwm_sched_pkg.sv
// Shared types and default sizes for the PWM scheduler slice.
package pwm_sched_pkg;

  localparam int unsigned NUM_CH_DEFAULT = 4;
  localparam int unsigned CNT_W_DEFAULT  = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STOP = 2'd2
  } sched_state_t;

endpackage

// File: rtl/pwm_channel_cmp.sv
// One PWM channel: shadow/active duty pair, pending flag and registered compare.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   wrap         current cycle is the period wrap cycle
//   wr_en        accepted duty write targeting this channel
//   idle         scheduler is idle (writes go straight to the active duty)
//   busy_next    scheduler will be running next cycle
//   wr_duty      duty value being written
//   cnt_next     counter value for the next cycle
//   pending      shadow value waiting for the next wrap
//   pwm          registered PWM output
module pwm_channel_cmp #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wrap,
  input  logic             wr_en,
  input  logic             idle,
  input  logic             busy_next,
  input  logic [CNT_W-1:0] wr_duty,
  input  logic [CNT_W-1:0] cnt_next,
  output logic             pending,
  output logic             pwm
);

  logic [CNT_W-1:0] duty_act;
  logic [CNT_W-1:0] duty_shd;
  logic [CNT_W-1:0] duty_act_next;
  logic [CNT_W-1:0] duty_shd_next;
  logic             pending_next;
  logic             pwm_next;

  // Wrap applies the old shadow first; a colliding write then re-arms pending.
  always_comb begin
    duty_act_next = duty_act;
    duty_shd_next = duty_shd;
    pending_next  = pending;
    if (wrap && pending) begin
      duty_act_next = duty_shd;
      pending_next  = 1'b0;
    end
    if (wr_en) begin
      duty_shd_next = wr_duty;
      if (idle) begin
        duty_act_next = wr_duty;
      end else begin
        pending_next = 1'b1;
      end
    end
    pwm_next = busy_next && (cnt_next < duty_act_next);
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_act <= '0;
      duty_shd <= '0;
      pending  <= 1'b0;
      pwm      <= 1'b0;
    end else begin
      duty_act <= duty_act_next;
      duty_shd <= duty_shd_next;
      pending  <= pending_next;
      pwm      <= pwm_next;
    end
  end

endmodule

// File: rtl/pwm_4ch_scheduler.sv
// Shared-timebase PWM scheduler: one period counter, NUM_CH channels,
// duty updates held in shadows and applied at period wrap, start/stop
// sequenced so a period is never truncated.
// Ports:
//   ACLK, ARESETN  clock, async active-low reset
//   enable         1 = run, 0 = stop at end of current period
//   period         period value P (period length P+1 cycles)
//   cfg_valid/cfg_ready/cfg_ch/cfg_duty  duty update handshake
//   pwm_out        registered PWM outputs
//   period_tick    high on the wrap cycle while running or stopping
//   pending        per-channel shadow waiting for next wrap
//   busy           scheduler not idle
module pwm_4ch_scheduler
  import pwm_sched_pkg::*;
#(
  parameter int unsigned NUM_CH = NUM_CH_DEFAULT,
  parameter int unsigned CNT_W  = CNT_W_DEFAULT,
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              enable,
  input  logic [CNT_W-1:0]  period,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_duty,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              period_tick,
  output logic [NUM_CH-1:0] pending,
  output logic              busy
);

  sched_state_t      state;
  sched_state_t      state_next;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic [CNT_W-1:0]  p_act;
  logic [CNT_W-1:0]  p_act_next;
  logic              wrap;
  logic              busy_next;
  logic              idle;
  logic [NUM_CH-1:0] wr_en;

  // Next-state, counter and active-period logic.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    p_act_next = p_act;
    wrap       = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable) begin
          state_next = S_RUN;
          cnt_next   = '0;
          p_act_next = period;
        end
      end
      S_RUN: begin
        wrap     = (cnt == p_act);
        cnt_next = wrap ? '0 : cnt + CNT_W'(1);
        if (wrap) begin
          p_act_next = period;
        end
        if (!enable) begin
          state_next = S_STOP;
        end
      end
      S_STOP: begin
        wrap     = (cnt == p_act);
        cnt_next = wrap ? '0 : cnt + CNT_W'(1);
        if (enable) begin
          // Resume without restarting; a resume on the wrap reloads the period.
          state_next = S_RUN;
          if (wrap) begin
            p_act_next = period;
          end
        end else if (wrap) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
    endcase
    busy_next = (state_next != S_IDLE);
  end

  // Config write decode.
  always_comb begin
    wr_en = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      wr_en[c] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(c));
    end
  end

  assign idle = (state == S_IDLE);

  // Scheduler registers; tick is aligned with the cycle where cnt == P_act.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state       <= S_IDLE;
      cnt         <= '0;
      p_act       <= '0;
      cfg_ready   <= 1'b0;
      period_tick <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      p_act       <= p_act_next;
      cfg_ready   <= 1'b1;
      period_tick <= busy_next && (cnt_next == p_act_next);
      busy        <= busy_next;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    pwm_channel_cmp #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk       (ACLK),
      .rst_n     (ARESETN),
      .wrap      (wrap),
      .wr_en     (wr_en[c]),
      .idle      (idle),
      .busy_next (busy_next),
      .wr_duty   (cfg_duty),
      .cnt_next  (cnt_next),
      .pending   (pending[c]),
      .pwm       (pwm_out[c])
    );
  end

endmodule

// File: tb/tb_pwm_4ch_scheduler.sv
// Directed bench for pwm_4ch_scheduler with a per-cycle expectation scoreboard.
module tb_pwm_4ch_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] period;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_ch;
  logic [15:0] cfg_duty;
  logic [3:0]  pwm_out;
  logic        period_tick;
  logic [3:0]  pending;
  logic        busy;

  int tests = 0;
  int fails = 0;
  int exp_duty [4];
  logic [10:0] exp_q [$];
  string       tag_q [$];

  always #5 clk = ~clk;

  pwm_4ch_scheduler dut (
    .ACLK        (clk),
    .ARESETN     (rst_n),
    .enable      (enable),
    .period      (period),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_ch      (cfg_ch),
    .cfg_duty    (cfg_duty),
    .pwm_out     (pwm_out),
    .period_tick (period_tick),
    .pending     (pending),
    .busy        (busy)
  );

  // Expected {ready, pwm[3:0], tick, busy, pending[3:0]} for a cycle at count k.
  function automatic logic [10:0] expect_vec(int k, int p, logic bz, logic [3:0] pend);
    logic [3:0] w;
    w = '0;
    for (int c = 0; c < 4; c++) w[c] = bz && (k < exp_duty[c]);
    return {1'b1, w, bz && (k == p), bz, pend};
  endfunction

  task automatic cyc(input int k, input int p, input logic bz, input logic [3:0] pend,
                     input string tag);
    logic [10:0] obs;
    logic [10:0] exp;
    string       t;
    exp_q.push_back(expect_vec(k, p, bz, pend));
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    obs = {cfg_ready, pwm_out, period_tick, busy, pending};
    exp = exp_q.pop_front();
    t   = tag_q.pop_front();
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s k=%0d: observed %b expected %b (ready,pwm,tick,busy,pend)", t, k, obs, exp);
    end
  endtask

  task automatic run(input int k0, input int k1, input int p, input logic bz,
                     input logic [3:0] pend, input string tag);
    for (int k = k0; k <= k1; k++) cyc(k, p, bz, pend, tag);
  endtask

  task automatic wr(input int ch, input int duty);
    cfg_valid = 1'b1;
    cfg_ch    = 2'(ch);
    cfg_duty  = 16'(duty);
  endtask

  task automatic wr_clear();
    cfg_valid = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    logic [10:0] obs;
    obs = {cfg_ready, pwm_out, period_tick, busy, pending};
    tests++;
    assert (obs === 11'b0) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, 11'b0);
    end
  endtask

  initial begin
    int d [4];
    d = '{3, 0, 10, 12};
    rst_n = 1'b0; enable = 1'b0; period = '0;
    cfg_valid = 1'b0; cfg_ch = '0; cfg_duty = '0;
    for (int c = 0; c < 4; c++) exp_duty[c] = 0;
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset_state");
    rst_n = 1'b1;
    cyc(0, 0, 1'b0, 4'b0000, "ready_up");

    // Idle writes land directly in the active duty.
    for (int c = 0; c < 4; c++) begin
      wr(c, d[c]);
      exp_duty[c] = d[c];
      cyc(0, 0, 1'b0, 4'b0000, "idle_wr");
    end
    wr_clear();

    period = 16'd9; enable = 1'b1;
    run(0, 9, 9, 1'b1, 4'b0000, "basic");
    run(0, 9, 9, 1'b1, 4'b0000, "basic");

    // Shadow write mid-period.
    run(0, 4, 9, 1'b1, 4'b0000, "shadow_pre");
    wr(0, 7);
    cyc(5, 9, 1'b1, 4'b0001, "shadow_wr");
    wr_clear();
    run(6, 9, 9, 1'b1, 4'b0001, "shadow_hold");
    exp_duty[0] = 7;
    run(0, 9, 9, 1'b1, 4'b0000, "shadow_apply");

    // Write colliding with wrap while a shadow is pending.
    run(0, 1, 9, 1'b1, 4'b0000, "coll_pre");
    wr(1, 6);
    cyc(2, 9, 1'b1, 4'b0010, "coll_first");
    wr_clear();
    run(3, 9, 9, 1'b1, 4'b0010, "coll_hold");
    wr(1, 2);
    exp_duty[1] = 6;
    cyc(0, 9, 1'b1, 4'b0010, "coll_wrap");
    wr_clear();
    run(1, 9, 9, 1'b1, 4'b0010, "coll_six");
    exp_duty[1] = 2;
    run(0, 9, 9, 1'b1, 4'b0000, "coll_two");

    // Stop completes the period, then idles.
    run(0, 3, 9, 1'b1, 4'b0000, "stop_pre");
    enable = 1'b0;
    run(4, 9, 9, 1'b1, 4'b0000, "stop_finish");
    cyc(0, 9, 1'b0, 4'b0000, "stop_idle");
    cyc(0, 9, 1'b0, 4'b0000, "stop_idle");

    // Re-enable during a stopping period keeps running.
    enable = 1'b1;
    run(0, 2, 9, 1'b1, 4'b0000, "restart");
    enable = 1'b0;
    run(3, 6, 9, 1'b1, 4'b0000, "stop_mid");
    enable = 1'b1;
    run(7, 9, 9, 1'b1, 4'b0000, "resume");
    run(0, 9, 9, 1'b1, 4'b0000, "resume_next");

    // Period change only at wrap.
    run(0, 2, 9, 1'b1, 4'b0000, "pchg_pre");
    period = 16'd4;
    run(3, 9, 9, 1'b1, 4'b0000, "pchg_old");
    run(0, 4, 4, 1'b1, 4'b0000, "pchg_new");
    run(0, 2, 4, 1'b1, 4'b0000, "pchg_new");
    wr(0, 1);
    period = 16'd0;
    cyc(3, 4, 1'b1, 4'b0001, "p0_wr");
    wr_clear();
    cyc(4, 4, 1'b1, 4'b0001, "p0_wr");
    exp_duty[0] = 1;
    run(0, 0, 0, 1'b1, 4'b0000, "p0");
    for (int i = 0; i < 7; i++) cyc(0, 0, 1'b1, 4'b0000, "p0");

    // Back to P=9 with duty0=5, then reset mid-run with a pending shadow.
    period = 16'd9;
    wr(0, 5);
    cyc(0, 9, 1'b1, 4'b0001, "p9_back");
    wr_clear();
    run(1, 9, 9, 1'b1, 4'b0001, "p9_back");
    exp_duty[0] = 5;
    run(0, 6, 9, 1'b1, 4'b0000, "duty5");
    wr(1, 3);
    cyc(7, 9, 1'b1, 4'b0010, "pre_rst");
    wr_clear();
    enable = 1'b0;
    rst_n  = 1'b0;
    #1;
    check_reset("rst_async");
    for (int c = 0; c < 4; c++) exp_duty[c] = 0;
    @(posedge clk);
    #1;
    check_reset("rst_held");
    rst_n = 1'b1;
    cyc(0, 9, 1'b0, 4'b0000, "rst_idle");
    enable = 1'b1;
    run(0, 9, 9, 1'b1, 4'b0000, "rst_restart");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
